// File: rtl/cmp_streak_monitor.sv
// -----------------------------------------------------------------------------
// cmp_streak_monitor
//
// Consumes one 2-bit comparator result (a_gt_b / a_eq_b / a_lt_b) per
// valid/ready handshake. It keeps a saturating counter per outcome and runs an
// equality-streak FSM. The FSM pulses match_pulse once STREAK_LEN consecutive
// accepted 'eq' results have been seen, then inserts a single-cycle bubble
// (HOLD, in_ready=0).
//
// Optional feature macro: CMP_ONEHOT_CHECK_EN
//   defined   : a result must be exactly one-hot. Anything else is malformed.
//               A malformed result counts nothing, breaks the streak and sets
//               the sticky err flag.
//   undefined : flags are priority-decoded eq > gt > lt. An all-zero result
//               counts nothing and breaks the streak. err is tied to 0.
//
// Parameters:
//   CNT_W       width of each outcome counter (default 8)
//   STREAK_LEN  consecutive eq results needed for a match, 1..255 (default 4)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (highest priority)
//   in_valid     a comparator result is presented
//   in_ready     block can accept a result (low only in HOLD)
//   a_gt_b       comparator flag: greater than
//   a_eq_b       comparator flag: equal
//   a_lt_b       comparator flag: less than
//   clr          synchronous clear of counters, streak and err
//   gt_cnt       accepted gt results, saturating
//   eq_cnt       accepted eq results, saturating
//   lt_cnt       accepted lt results, saturating
//   streak       current consecutive-eq count
//   match_pulse  one-cycle pulse when the streak reaches STREAK_LEN
//   err          sticky malformed-result flag
// -----------------------------------------------------------------------------
module cmp_streak_monitor #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned STREAK_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a_gt_b,
    input  logic             a_eq_b,
    input  logic             a_lt_b,
    input  logic             clr,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [7:0]       streak,
    output logic             match_pulse,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [7:0]       STREAK_TGT = 8'(STREAK_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t     state;
    logic       xfer;
    logic       is_gt;
    logic       is_eq;
    logic       is_lt;
    logic       is_bad;
    logic [7:0] streak_inc;

    // Ready is a pure function of state: only the post-match bubble stalls.
    assign in_ready   = (state != HOLD);
    assign xfer       = in_valid && in_ready;
    assign streak_inc = streak + 8'd1;

    // -------------------------------------------------------------------------
    // Result decode
    // -------------------------------------------------------------------------
`ifdef CMP_ONEHOT_CHECK_EN
    always_comb begin
        is_gt  = 1'b0;
        is_eq  = 1'b0;
        is_lt  = 1'b0;
        is_bad = 1'b1;
        case ({a_gt_b, a_eq_b, a_lt_b})
            3'b100: begin is_gt = 1'b1; is_bad = 1'b0; end
            3'b010: begin is_eq = 1'b1; is_bad = 1'b0; end
            3'b001: begin is_lt = 1'b1; is_bad = 1'b0; end
            default: is_bad = 1'b1;
        endcase
    end
`else
    always_comb begin
        is_eq  = a_eq_b;
        is_gt  = !a_eq_b && a_gt_b;
        is_lt  = !a_eq_b && !a_gt_b && a_lt_b;
        is_bad = 1'b0;
    end

    assign err = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Counters and streak FSM
    // -------------------------------------------------------------------------
    // rst and clr have identical effect on every register. A transfer that
    // coincides with clr still completes its handshake (in_ready is
    // unaffected) but is discarded here.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state       <= IDLE;
            streak      <= '0;
            gt_cnt      <= '0;
            eq_cnt      <= '0;
            lt_cnt      <= '0;
            match_pulse <= 1'b0;
`ifdef CMP_ONEHOT_CHECK_EN
            err         <= 1'b0;
`endif
        end else begin
            match_pulse <= 1'b0;
            case (state)
                IDLE, COUNT: begin
                    if (xfer) begin
                        if (is_eq) begin
                            if (eq_cnt != CNT_MAX) begin
                                eq_cnt <= eq_cnt + CNT_ONE;
                            end
                            // IDLE holds streak=0, so one increment path covers
                            // both the first eq and later ones, including
                            // STREAK_LEN==1.
                            streak <= streak_inc;
                            if (streak_inc == STREAK_TGT) begin
                                state       <= HOLD;
                                match_pulse <= 1'b1;
                            end else begin
                                state <= COUNT;
                            end
                        end else begin
                            if (is_gt && (gt_cnt != CNT_MAX)) begin
                                gt_cnt <= gt_cnt + CNT_ONE;
                            end
                            if (is_lt && (lt_cnt != CNT_MAX)) begin
                                lt_cnt <= lt_cnt + CNT_ONE;
                            end
`ifdef CMP_ONEHOT_CHECK_EN
                            if (is_bad) begin
                                err <= 1'b1;
                            end
`endif
                            streak <= '0;
                            state  <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    streak <= '0;
                    state  <= IDLE;
                end
                default: begin
                    streak <= '0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_streak_monitor.sv
// -----------------------------------------------------------------------------
// Bench for cmp_streak_monitor (CNT_W=3, STREAK_LEN=4).
// The stimulus process drives one vector per cycle. At each rising edge it
// advances a small reference model and queues the outputs expected for the
// following cycle. An independent monitor pops one entry per falling edge and
// compares every output field.
// -----------------------------------------------------------------------------
module tb_cmp_streak_monitor;

    localparam int unsigned CW   = 3;
    localparam int unsigned SLEN = 4;
    localparam int unsigned MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          a_gt_b;
    logic          a_eq_b;
    logic          a_lt_b;
    logic          clr;
    logic [CW-1:0] gt_cnt;
    logic [CW-1:0] eq_cnt;
    logic [CW-1:0] lt_cnt;
    logic [7:0]    streak;
    logic          match_pulse;
    logic          err;

    cmp_streak_monitor #(.CNT_W(CW), .STREAK_LEN(SLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_gt_b     (a_gt_b),
        .a_eq_b     (a_eq_b),
        .a_lt_b     (a_lt_b),
        .clr        (clr),
        .gt_cnt     (gt_cnt),
        .eq_cnt     (eq_cnt),
        .lt_cnt     (lt_cnt),
        .streak     (streak),
        .match_pulse(match_pulse),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned rdy;
        int unsigned gt;
        int unsigned eq;
        int unsigned lt;
        int unsigned stk;
        int unsigned pulse;
        int unsigned err;
    } exp_t;

    exp_t q[$];

    int unsigned errors = 0;
    int unsigned checks = 0;

    // reference model state
    int unsigned m_gt = 0, m_eq = 0, m_lt = 0, m_stk = 0;
    bit          m_hold = 0, m_pulse = 0, m_err = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour at one rising edge, given the inputs held across it.
    task automatic model_edge(input bit v, input bit g, input bit e, input bit l,
                              input bit c, input bit r);
        bit accept;
        bit k_gt, k_eq, k_lt, k_bad;
        accept  = v && !m_hold;
        m_pulse = 0;
        if (r || c) begin
            m_gt = 0; m_eq = 0; m_lt = 0; m_stk = 0; m_hold = 0; m_err = 0;
        end else if (m_hold) begin
            m_hold = 0;
            m_stk  = 0;
        end else if (accept) begin
`ifdef CMP_ONEHOT_CHECK_EN
            k_bad = (int'(g) + int'(e) + int'(l)) != 1;
            k_gt  = !k_bad && g;
            k_eq  = !k_bad && e;
            k_lt  = !k_bad && l;
`else
            k_bad = 0;
            k_eq  = e;
            k_gt  = !e && g;
            k_lt  = !e && !g && l;
`endif
            if (k_eq) begin
                if (m_eq < MAXC) m_eq++;
                m_stk++;
                if (m_stk == SLEN) begin
                    m_hold  = 1;
                    m_pulse = 1;
                end
            end else begin
                if (k_gt && m_gt < MAXC) m_gt++;
                if (k_lt && m_lt < MAXC) m_lt++;
                if (k_bad) m_err = 1;
                m_stk = 0;
            end
        end
    endtask

    // One cycle of stimulus: apply inputs, cross the edge, queue expectations.
    task automatic drive(input bit v, input bit g, input bit e, input bit l,
                         input bit c, input bit r);
        exp_t x;
        in_valid = v; a_gt_b = g; a_eq_b = e; a_lt_b = l; clr = c; rst = r;
        @(posedge clk);
        model_edge(v, g, e, l, c, r);
        x.rdy   = m_hold ? 0 : 1;
        x.gt    = m_gt;
        x.eq    = m_eq;
        x.lt    = m_lt;
        x.stk   = m_stk;
        x.pulse = m_pulse;
        x.err   = m_err;
        q.push_back(x);
        #1;
    endtask

    task automatic eq_t();   drive(1, 0, 1, 0, 0, 0); endtask
    task automatic gt_t();   drive(1, 1, 0, 0, 0, 0); endtask
    task automatic lt_t();   drive(1, 0, 0, 1, 0, 0); endtask
    task automatic idle_t(); drive(0, 0, 0, 0, 0, 0); endtask
    task automatic clr_t();  drive(0, 0, 0, 0, 1, 0); endtask

    // Monitor: every cycle after an edge the DUT presents a full output set.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("in_ready",    32'(in_ready),    x.rdy);
                chk("gt_cnt",      32'(gt_cnt),      x.gt);
                chk("eq_cnt",      32'(eq_cnt),      x.eq);
                chk("lt_cnt",      32'(lt_cnt),      x.lt);
                chk("streak",      32'(streak),      x.stk);
                chk("match_pulse", 32'(match_pulse), x.pulse);
                chk("err",         32'(err),         x.err);
            end
        end
    end

    initial begin
        in_valid = 0; a_gt_b = 0; a_eq_b = 0; a_lt_b = 0; clr = 0; rst = 1;

        // reset
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        idle_t();

        // four eq -> match, bubble, then valid offered during HOLD is not taken
        repeat (4) eq_t();
        eq_t();      // HOLD cycle: in_ready=0, ignored
        idle_t();
        clr_t();

        // eq,eq,eq,gt,eq -> no match, streak ends at 1
        eq_t(); eq_t(); eq_t(); gt_t(); eq_t();
        // valid low inside COUNT does not break the streak
        idle_t(); eq_t(); idle_t(); idle_t(); eq_t(); eq_t();   // reaches 4 -> match
        idle_t();
        clr_t();

        // lt saturation at 7
        repeat (9) lt_t();
        idle_t();
        clr_t();

        // gt saturation, and eq saturation across two matches
        repeat (8) gt_t();
        repeat (4) eq_t();
        idle_t();
        repeat (4) eq_t();   // eq_cnt saturates at 7 on the 8th eq, match still fires
        idle_t();
        clr_t();

        // malformed gt+eq mid-streak, then an all-zero result, then clr
        eq_t(); eq_t();
        drive(1, 1, 1, 0, 0, 0);
        eq_t(); lt_t();
        drive(1, 0, 0, 0, 0, 0);
        eq_t();
        drive(1, 1, 1, 1, 0, 0);
        idle_t();
        clr_t();
        idle_t();

        // clr on the 4th eq accept -> no match, everything zero
        eq_t(); eq_t(); eq_t();
        drive(1, 0, 1, 0, 1, 0);
        idle_t();
        eq_t();

        // rst during HOLD
        clr_t();
        repeat (4) eq_t();
        drive(1, 0, 1, 0, 0, 1);
        idle_t();

        // rst beats clr mid-streak
        eq_t(); eq_t();
        drive(1, 0, 1, 0, 1, 1);
        idle_t();

        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety bound in case the stimulus process stalls.
    initial begin
        #100000;
        $display("FAIL timeout: got %0d expected %0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cmp_streak_monitor.md
# cmp_streak_monitor

Downstream consumer of the 2-bit comparator's `a_gt_b`/`a_eq_b`/`a_lt_b` flags. It accepts one comparison result per valid/ready handshake and keeps saturating per-outcome counters. An equality-streak FSM pulses `match_pulse` after `STREAK_LEN` consecutive equal results. It sits between the comparator and the chip's status/readout logic.

## Interface
Parameters:
- `CNT_W`, default 8, width of each outcome counter.
- `STREAK_LEN`, default 4, consecutive accepted `eq` results needed to fire a match. Legal range is 1..255.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  a comparator result is presented.
- `in_ready`  out  1  the block can accept a result.
- `a_gt_b`  in  1  comparator flag: greater than.
- `a_eq_b`  in  1  comparator flag: equal.
- `a_lt_b`  in  1  comparator flag: less than.
- `clr`  in  1  synchronous clear of counters, streak and error.
- `gt_cnt`  out  CNT_W  accepted `gt` results, saturating.
- `eq_cnt`  out  CNT_W  accepted `eq` results, saturating.
- `lt_cnt`  out  CNT_W  accepted `lt` results, saturating.
- `streak`  out  8  current consecutive-`eq` count.
- `match_pulse`  out  1  one-cycle pulse when the streak reaches `STREAK_LEN`.
- `err`  out  1  sticky flag for a malformed (non-one-hot) result.

## Operation
- A transfer happens on a rising edge where `in_valid && in_ready`.
- `in_ready` is combinational from the FSM state: 1 in IDLE and COUNT, 0 in HOLD.
- Result decode is checked (see Configuration). A result is one of `gt`, `eq`, `lt` or malformed.
- On each accepted `gt`/`eq`/`lt`, the matching counter increments. It saturates at 2^CNT_W−1 and never wraps.
- FSM states and transitions:
  - IDLE (`streak`=0): an accepted `eq` sets `streak`=1 and moves to COUNT. If `STREAK_LEN`==1 it moves to HOLD instead and fires `match_pulse`. Any other accepted result stays in IDLE.
  - COUNT: an accepted `eq` increments `streak`. When the new value equals `STREAK_LEN`, the FSM goes to HOLD and fires `match_pulse`. An accepted non-`eq` or malformed result sets `streak`=0 and returns to IDLE. With no transfer, the state holds.
  - HOLD: `in_ready`=0 for exactly one cycle. Next state is IDLE with `streak`=0.
- An accepted malformed result leaves all counters unchanged, resets the streak to IDLE and sets `err`.
- `clr` has priority over a same-cycle transfer. The transfer is still consumed (handshake completes) but has no effect. `clr` zeroes all counters, `streak` and `err`, forces IDLE and suppresses `match_pulse`.
- `rst` has priority over `clr` and over any operation, including a reset in HOLD or mid-streak.

## Timing
- Reset values: `gt_cnt`=`eq_cnt`=`lt_cnt`=0, `streak`=0, `match_pulse`=0, `err`=0, state IDLE, so `in_ready`=1.
- Counters, `streak` and `err` are registered. They update on the edge that accepts the transfer and are visible the following cycle (latency 1).
- `match_pulse` is registered. It is high for the single cycle following the accepting edge, which is the same cycle the FSM is in HOLD with `in_ready`=0.
- Maximum throughput is one result per cycle, except that one bubble always follows every match.
- When a counter is saturated and another result of that type is accepted, the counter holds at max. The streak logic is unaffected.
- `in_valid` low while in COUNT does not break the streak; only accepted results count.

## Configuration
- Macro: `CMP_ONEHOT_CHECK_EN`.
- Defined:
  - A result is malformed unless exactly one flag is set.
  - Malformed results follow the malformed path in Operation, and `err` is sticky until `clr` or `rst`.
- Undefined:
  - No check is made. Flags are decoded by priority: `eq`, then `gt`, then `lt`.
  - An all-zero result is accepted, counts nothing and resets the streak.
  - `err` is tied to 0.

## Test plan
- Reset, then 4 consecutive `eq` transfers (`STREAK_LEN`=4) → `eq_cnt`=4. `match_pulse` is high for exactly one cycle after the 4th accept, `in_ready`=0 in that cycle, and `streak` reads 0 the cycle after.
- Sequence `eq,eq,eq,gt,eq` → no `match_pulse`, `gt_cnt`=1, `eq_cnt`=4, final `streak`=1.
- `CNT_W`=3, 9 `lt` transfers → `lt_cnt` saturates at 7 and stays there; the other counters remain 0.
- With `CMP_ONEHOT_CHECK_EN`: flags `gt`=1,`eq`=1 accepted mid-streak → counters unchanged, `streak`=0, `err`=1 and held through later valid results until `clr`. Without the macro, the same input counts as `eq` and `err` stays 0.
- `clr` asserted in the same cycle as the 4th `eq` accept → handshake completes, no `match_pulse`, all counters 0, state IDLE.
- `rst` asserted during HOLD → next cycle `in_ready`=1 and all outputs at their reset values.
